tlul_arbiter_2m: RTL and testbench

Two-master TileLink-UL arbiter that shares one SRAM-style TL slave between two requesters. On the A channel it arbitrates round-robin, holds a grant until the A beat is accepted, and tags the slave-side source with the master index. On the D channel it routes responses back by that tag. It also enforces a per-master outstanding-transaction limit and sits directly in front of the SRAM slave port.

---
 rtl/tlul_arbiter_2m.sv | 205 ++++++++++++++++++++
 tb/tb_tlul_arbiter_2m.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_arbiter_2m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlul_arbiter_2m : two-master TL-UL round-robin arbiter, source tagging,    |
// |                   D routing and per-master outstanding limit.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tlul_arbiter_2m #(
  parameter int AW  = 32,
  parameter int RS  = 4,
  parameter int MAX = 2
) (
  input  logic                       arb_clock_i,
  input  logic                       arb_reset_i,
  input  logic [2:0]                 m0_a_opcode,
  input  logic [2:0]                 m0_a_param,
  input  logic [3:0]                 m0_a_size,
  input  logic [RS-1:0]              m0_a_source,
  input  logic [AW-1:0]              m0_a_address,
  input  logic [3:0]                 m0_a_mask,
  input  logic [31:0]                m0_a_data,
  input  logic                       m0_a_corrupt,
  input  logic                       m0_a_valid,
  output logic                       m0_a_ready,
  input  logic [2:0]                 m1_a_opcode,
  input  logic [2:0]                 m1_a_param,
  input  logic [3:0]                 m1_a_size,
  input  logic [RS-1:0]              m1_a_source,
  input  logic [AW-1:0]              m1_a_address,
  input  logic [3:0]                 m1_a_mask,
  input  logic [31:0]                m1_a_data,
  input  logic                       m1_a_corrupt,
  input  logic                       m1_a_valid,
  output logic                       m1_a_ready,
  output logic [2:0]                 m0_d_opcode,
  output logic [1:0]                 m0_d_param,
  output logic [3:0]                 m0_d_size,
  output logic [RS-1:0]              m0_d_source,
  output logic                       m0_d_denied,
  output logic [31:0]                m0_d_data,
  output logic                       m0_d_corrupt,
  output logic                       m0_d_valid,
  input  logic                       m0_d_ready,
  output logic [2:0]                 m1_d_opcode,
  output logic [1:0]                 m1_d_param,
  output logic [3:0]                 m1_d_size,
  output logic [RS-1:0]              m1_d_source,
  output logic                       m1_d_denied,
  output logic [31:0]                m1_d_data,
  output logic                       m1_d_corrupt,
  output logic                       m1_d_valid,
  input  logic                       m1_d_ready,
  output logic [2:0]                 s_a_opcode,
  output logic [2:0]                 s_a_param,
  output logic [3:0]                 s_a_size,
  output logic [RS:0]                s_a_source,
  output logic [AW-1:0]              s_a_address,
  output logic [3:0]                 s_a_mask,
  output logic [31:0]                s_a_data,
  output logic                       s_a_corrupt,
  output logic                       s_a_valid,
  input  logic                       s_a_ready,
  input  logic [2:0]                 s_d_opcode,
  input  logic [1:0]                 s_d_param,
  input  logic [3:0]                 s_d_size,
  input  logic [RS:0]                s_d_source,
  input  logic                       s_d_denied,
  input  logic [31:0]                s_d_data,
  input  logic                       s_d_corrupt,
  input  logic                       s_d_valid,
  output logic                       s_d_ready,
  output logic [$clog2(MAX+1)-1:0]   outstanding0_o,
  output logic [$clog2(MAX+1)-1:0]   outstanding1_o,
  output logic                       err_o
);

  localparam int              CW    = $clog2(MAX + 1);
  localparam logic [CW-1:0]   C_MAX = CW'(MAX);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e   r_state, w_state_nxt;
  logic          r_lock_idx, w_lock_idx_nxt;
  logic          r_last;
  logic [CW-1:0] r_cnt0, r_cnt1;
  logic          r_err;

  logic w_elig0, w_elig1, w_gnt, w_idx, w_a_fire;
  logic w_d_sel, w_d_fire;
  logic w_a_fire0, w_a_fire1, w_d_fire0, w_d_fire1;

  assign w_elig0 = m0_a_valid && (r_cnt0 < C_MAX);
  assign w_elig1 = m1_a_valid && (r_cnt1 < C_MAX);

  // A held beat keeps its grant regardless of eligibility so the slave never sees it change.
  always_comb begin
    w_gnt = 1'b0;
    w_idx = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_gnt = 1'b1;
      w_idx = r_lock_idx;
    end else if (w_elig0 && w_elig1) begin
      w_gnt = 1'b1;
      w_idx = ~r_last;
    end else if (w_elig0) begin
      w_gnt = 1'b1;
      w_idx = 1'b0;
    end else if (w_elig1) begin
      w_gnt = 1'b1;
      w_idx = 1'b1;
    end
    if (arb_reset_i) begin
      w_gnt = 1'b0;
    end
  end

  assign s_a_valid   = w_gnt;
  assign s_a_opcode  = w_idx ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = w_idx ? m1_a_param   : m0_a_param;
  assign s_a_size    = w_idx ? m1_a_size    : m0_a_size;
  assign s_a_source  = {w_idx, (w_idx ? m1_a_source : m0_a_source)};
  assign s_a_address = w_idx ? m1_a_address : m0_a_address;
  assign s_a_mask    = w_idx ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = w_idx ? m1_a_data    : m0_a_data;
  assign s_a_corrupt = w_idx ? m1_a_corrupt : m0_a_corrupt;
  assign m0_a_ready  = w_gnt && !w_idx && s_a_ready;
  assign m1_a_ready  = w_gnt &&  w_idx && s_a_ready;
  assign w_a_fire    = w_gnt && s_a_ready;
  assign w_a_fire0   = w_a_fire && !w_idx;
  assign w_a_fire1   = w_a_fire &&  w_idx;

  assign w_d_sel      = s_d_source[RS];
  assign m0_d_valid   = !arb_reset_i && s_d_valid && !w_d_sel;
  assign m1_d_valid   = !arb_reset_i && s_d_valid &&  w_d_sel;
  assign s_d_ready    = !arb_reset_i && (w_d_sel ? m1_d_ready : m0_d_ready);
  assign w_d_fire     = s_d_valid && s_d_ready;
  assign w_d_fire0    = w_d_fire && !w_d_sel;
  assign w_d_fire1    = w_d_fire &&  w_d_sel;

  assign m0_d_opcode  = s_d_opcode;
  assign m0_d_param   = s_d_param;
  assign m0_d_size    = s_d_size;
  assign m0_d_source  = s_d_source[RS-1:0];
  assign m0_d_denied  = s_d_denied;
  assign m0_d_data    = s_d_data;
  assign m0_d_corrupt = s_d_corrupt;
  assign m1_d_opcode  = s_d_opcode;
  assign m1_d_param   = s_d_param;
  assign m1_d_size    = s_d_size;
  assign m1_d_source  = s_d_source[RS-1:0];
  assign m1_d_denied  = s_d_denied;
  assign m1_d_data    = s_d_data;
  assign m1_d_corrupt = s_d_corrupt;

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_idx_nxt = r_lock_idx;
    if (r_state == ST_UNLOCKED) begin
      if (w_gnt && !s_a_ready) begin
        w_state_nxt    = ST_LOCKED;
        w_lock_idx_nxt = w_idx;
      end
    end else if (w_a_fire) begin
      w_state_nxt = ST_UNLOCKED;
    end
  end

  // Same-cycle issue and retire cancel; a retire at zero is an error and never wraps.
  function automatic logic [CW-1:0] f_cnt_nxt(input logic [CW-1:0] cnt,
                                              input logic inc, input logic dec);
    if (inc && !dec) return cnt + CW'(1);
    if (dec && !inc && (cnt != '0)) return cnt - CW'(1);
    return cnt;
  endfunction

  always_ff @(posedge arb_clock_i) begin
    if (arb_reset_i) begin
      r_state    <= ST_UNLOCKED;
      r_lock_idx <= 1'b0;
      r_last     <= 1'b1;
      r_cnt0     <= '0;
      r_cnt1     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_idx_nxt;
      if (w_a_fire) begin
        r_last <= w_idx;
      end
      r_cnt0 <= f_cnt_nxt(r_cnt0, w_a_fire0, w_d_fire0);
      r_cnt1 <= f_cnt_nxt(r_cnt1, w_a_fire1, w_d_fire1);
      if ((w_d_fire0 && (r_cnt0 == '0)) || (w_d_fire1 && (r_cnt1 == '0))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outstanding0_o = r_cnt0;
  assign outstanding1_o = r_cnt1;
  assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tlul_arbiter_2m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tlul_arbiter_2m : scoreboard bench for the two-master TL-UL arbiter.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tlul_arbiter_2m;
  localparam int AW  = 32;
  localparam int RS  = 4;
  localparam int MAX = 2;
  localparam int CW  = $clog2(MAX + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
  logic [3:0] m0_a_size, m0_a_mask, m1_a_size, m1_a_mask;
  logic [RS-1:0] m0_a_source, m1_a_source;
  logic [AW-1:0] m0_a_address, m1_a_address;
  logic [31:0] m0_a_data, m1_a_data;
  logic m0_a_corrupt, m0_a_valid, m0_a_ready, m1_a_corrupt, m1_a_valid, m1_a_ready;
  logic [2:0] m0_d_opcode, m1_d_opcode;
  logic [1:0] m0_d_param, m1_d_param;
  logic [3:0] m0_d_size, m1_d_size;
  logic [RS-1:0] m0_d_source, m1_d_source;
  logic m0_d_denied, m0_d_corrupt, m0_d_valid, m0_d_ready;
  logic m1_d_denied, m1_d_corrupt, m1_d_valid, m1_d_ready;
  logic [31:0] m0_d_data, m1_d_data;
  logic [2:0] s_a_opcode, s_a_param;
  logic [3:0] s_a_size, s_a_mask;
  logic [RS:0] s_a_source;
  logic [AW-1:0] s_a_address;
  logic [31:0] s_a_data;
  logic s_a_corrupt, s_a_valid, s_a_ready;
  logic [2:0] s_d_opcode;
  logic [1:0] s_d_param;
  logic [3:0] s_d_size;
  logic [RS:0] s_d_source;
  logic s_d_denied, s_d_corrupt, s_d_valid, s_d_ready;
  logic [31:0] s_d_data;
  logic [CW-1:0] outstanding0_o, outstanding1_o;
  logic err_o;

  tlul_arbiter_2m #(.AW(AW), .RS(RS), .MAX(MAX)) dut (
    .arb_clock_i(clk), .arb_reset_i(rst),
    .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param), .m0_a_size(m0_a_size),
    .m0_a_source(m0_a_source), .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask),
    .m0_a_data(m0_a_data), .m0_a_corrupt(m0_a_corrupt), .m0_a_valid(m0_a_valid),
    .m0_a_ready(m0_a_ready),
    .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param), .m1_a_size(m1_a_size),
    .m1_a_source(m1_a_source), .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask),
    .m1_a_data(m1_a_data), .m1_a_corrupt(m1_a_corrupt), .m1_a_valid(m1_a_valid),
    .m1_a_ready(m1_a_ready),
    .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
    .m0_d_source(m0_d_source), .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data),
    .m0_d_corrupt(m0_d_corrupt), .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
    .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
    .m1_d_source(m1_d_source), .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data),
    .m1_d_corrupt(m1_d_corrupt), .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
    .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
    .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
    .s_a_data(s_a_data), .s_a_corrupt(s_a_corrupt), .s_a_valid(s_a_valid),
    .s_a_ready(s_a_ready),
    .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
    .s_d_source(s_d_source), .s_d_denied(s_d_denied), .s_d_data(s_d_data),
    .s_d_corrupt(s_d_corrupt), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
    .outstanding0_o(outstanding0_o), .outstanding1_o(outstanding1_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [RS:0]   src;
    logic [AW-1:0] addr;
    logic [2:0]    op;
  } a_exp_t;

  typedef struct packed {
    logic          sel;
    logic [RS-1:0] src;
    logic [31:0]   data;
  } d_exp_t;

  a_exp_t exp_a[$];
  d_exp_t exp_d[$];
  int checks = 0;
  int errors = 0;

  // Master 0 issues Gets at 0x1000_000x, master 1 PutFulls at 0x2000_000x.
  function automatic logic [AW-1:0] addr_of(input logic idx, input logic [RS-1:0] src);
    return (idx ? 32'h2000_0000 : 32'h1000_0000) | {28'h0, src};
  endfunction

  task automatic push_a(input logic idx, input logic [RS-1:0] src);
    exp_a.push_back('{src: {idx, src}, addr: addr_of(idx, src), op: (idx ? 3'd0 : 3'd4)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic v, input logic [RS-1:0] src);
    m0_a_valid = v; m0_a_source = src; m0_a_address = addr_of(1'b0, src);
    m0_a_opcode = 3'd4; m0_a_data = 32'hD000_0000 | {28'h0, src};
  endtask

  task automatic drive_m1(input logic v, input logic [RS-1:0] src);
    m1_a_valid = v; m1_a_source = src; m1_a_address = addr_of(1'b1, src);
    m1_a_opcode = 3'd0; m1_a_data = 32'hE000_0000 | {28'h0, src};
  endtask

  task automatic d_beat(input logic sel, input logic [RS-1:0] src, input logic [31:0] data);
    exp_d.push_back('{sel: sel, src: src, data: data});
    s_d_valid = 1'b1; s_d_source = {sel, src}; s_d_data = data;
    m0_d_ready = 1'b1; m1_d_ready = 1'b1;
    step();
    s_d_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (s_a_valid && s_a_ready) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected src=%h addr=%h", s_a_source, s_a_address);
      end else begin
        a_exp_t e;
        e = exp_a.pop_front();
        if ({s_a_source, s_a_address, s_a_opcode} !== {e.src, e.addr, e.op}) begin
          errors++;
          $display("FAIL a_beat got src=%h addr=%h op=%0d want src=%h addr=%h op=%0d",
                   s_a_source, s_a_address, s_a_opcode, e.src, e.addr, e.op);
        end
      end
    end
    if (s_d_valid && s_d_ready) begin
      checks++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("FAIL d_unexpected src=%h", s_d_source);
      end else begin
        d_exp_t e;
        e = exp_d.pop_front();
        if ({m1_d_valid, m0_d_valid} !== (e.sel ? 2'b10 : 2'b01) ||
            m0_d_source !== e.src || m1_d_source !== e.src ||
            m0_d_data !== e.data || m1_d_data !== e.data) begin
          errors++;
          $display("FAIL d_route got v=%b%b src=%h/%h data=%h want sel=%b src=%h data=%h",
                   m1_d_valid, m0_d_valid, m1_d_source, m0_d_source, m0_d_data,
                   e.sel, e.src, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    drive_m0(1'b1, 4'h1); drive_m1(1'b1, 4'h2);
    s_a_ready = 1'b1; s_d_valid = 1'b1; s_d_source = 5'h10;
    m0_d_ready = 1'b1; m1_d_ready = 1'b1;
    step(); step();
    @(negedge clk);
    checks++;
    if ({s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshakes got %b want 000000",
               {s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready});
    end
    checks++;
    if (outstanding0_o !== '0 || outstanding1_o !== '0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got cnt0=%0d cnt1=%0d err=%b want 0 0 0",
               outstanding0_o, outstanding1_o, err_o);
    end
    step();
    drive_m0(1'b0, 4'h0); drive_m1(1'b0, 4'h0);
    s_a_ready = 1'b0; s_d_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    drive_m0(1'b1, 4'h3); drive_m1(1'b1, 4'h7); s_a_ready = 1'b1;
    push_a(1'b0, 4'h3); push_a(1'b1, 4'h7); push_a(1'b0, 4'h3); push_a(1'b1, 4'h7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (s_a_source[RS] !== i[0]) begin
        errors++;
        $display("FAIL rr_grant cycle=%0d got idx=%b want %b", i, s_a_source[RS], i[0]);
      end
      step();
    end
    drive_m0(1'b0, 4'h0); drive_m1(1'b0, 4'h0); s_a_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding0_o !== 2'd2 || outstanding1_o !== 2'd2) begin
      errors++;
      $display("FAIL rr_counts got %0d %0d want 2 2", outstanding0_o, outstanding1_o);
    end
    step();
    d_beat(1'b0, 4'h3, 32'h0000_0A03); d_beat(1'b0, 4'h3, 32'h0000_0B03);
    d_beat(1'b1, 4'h7, 32'h0000_0A07); d_beat(1'b1, 4'h7, 32'h0000_0B07);
    @(negedge clk);
    checks++;
    if (outstanding0_o !== 2'd0 || outstanding1_o !== 2'd0) begin
      errors++;
      $display("FAIL rr_drain got %0d %0d want 0 0", outstanding0_o, outstanding1_o);
    end
  endtask

  task automatic test_lock();
    // One m0 beat first so last=0: an unlocked arbiter would then favour m1.
    drive_m0(1'b1, 4'h1); s_a_ready = 1'b1; push_a(1'b0, 4'h1);
    step();
    drive_m0(1'b1, 4'h2); s_a_ready = 1'b0;
    push_a(1'b0, 4'h2); push_a(1'b1, 4'h5);
    @(negedge clk);
    checks++;
    if (s_a_valid !== 1'b1 || s_a_source !== 5'h02 || m0_a_ready !== 1'b0) begin
      errors++;
      $display("FAIL lock_first got v=%b src=%h rdy0=%b want 1 02 0",
               s_a_valid, s_a_source, m0_a_ready);
    end
    step();
    drive_m1(1'b1, 4'h5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (s_a_source !== 5'h02 || s_a_address !== 32'h1000_0002 || m1_a_ready !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold cycle=%0d got src=%h addr=%h rdy1=%b want 02 10000002 0",
                 i, s_a_source, s_a_address, m1_a_ready);
      end
      step();
    end
    s_a_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m0_a_ready !== 1'b1 || m1_a_ready !== 1'b0) begin
      errors++;
      $display("FAIL lock_release got rdy0=%b rdy1=%b want 1 0", m0_a_ready, m1_a_ready);
    end
    step();
    drive_m0(1'b0, 4'h0);
    @(negedge clk);
    checks++;
    if (s_a_source !== 5'h15 || m1_a_ready !== 1'b1) begin
      errors++;
      $display("FAIL lock_next got src=%h rdy1=%b want 15 1", s_a_source, m1_a_ready);
    end
    step();
    drive_m1(1'b0, 4'h0); s_a_ready = 1'b0;
    d_beat(1'b0, 4'h1, 32'h11); d_beat(1'b0, 4'h2, 32'h12); d_beat(1'b1, 4'h5, 32'h15);
  endtask

  task automatic test_limit();
    drive_m0(1'b1, 4'h1); s_a_ready = 1'b1;
    push_a(1'b0, 4'h1); push_a(1'b0, 4'h1);
    step(); step();
    @(negedge clk);
    checks++;
    if (m0_a_ready !== 1'b0 || s_a_valid !== 1'b0 || outstanding0_o !== 2'd2) begin
      errors++;
      $display("FAIL limit_block got rdy0=%b sv=%b cnt0=%0d want 0 0 2",
               m0_a_ready, s_a_valid, outstanding0_o);
    end
    d_beat(1'b0, 4'h1, 32'h21);
    push_a(1'b0, 4'h1);
    @(negedge clk);
    checks++;
    if (m0_a_ready !== 1'b1 || s_a_valid !== 1'b1) begin
      errors++;
      $display("FAIL limit_reopen got rdy0=%b sv=%b want 1 1", m0_a_ready, s_a_valid);
    end
    step();
    drive_m0(1'b0, 4'h0); s_a_ready = 1'b0;
    d_beat(1'b0, 4'h1, 32'h22); d_beat(1'b0, 4'h1, 32'h23);
  endtask

  task automatic test_d_backpressure();
    drive_m1(1'b1, 4'h5); s_a_ready = 1'b1; push_a(1'b1, 4'h5);
    step();
    drive_m1(1'b0, 4'h0); s_a_ready = 1'b0;
    s_d_valid = 1'b1; s_d_source = 5'h15; s_d_data = 32'hA5A5_0001;
    m0_d_ready = 1'b1; m1_d_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (m1_d_valid !== 1'b1 || m0_d_valid !== 1'b0 || m1_d_source !== 4'h5 ||
          s_d_ready !== 1'b0 || outstanding1_o !== 2'd1) begin
        errors++;
        $display("FAIL d_stall cycle=%0d got v1=%b v0=%b src=%h rdy=%b cnt1=%0d want 1 0 5 0 1",
                 i, m1_d_valid, m0_d_valid, m1_d_source, s_d_ready, outstanding1_o);
      end
      step();
    end
    m1_d_ready = 1'b1;
    exp_d.push_back('{sel: 1'b1, src: 4'h5, data: 32'hA5A5_0001});
    @(negedge clk);
    checks++;
    if (s_d_ready !== 1'b1) begin
      errors++;
      $display("FAIL d_go got rdy=%b want 1", s_d_ready);
    end
    step();
    s_d_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding1_o !== 2'd0) begin
      errors++;
      $display("FAIL d_dec got cnt1=%0d want 0", outstanding1_o);
    end
  endtask

  task automatic test_simultaneous_and_err();
    drive_m1(1'b1, 4'h6); s_a_ready = 1'b1; push_a(1'b1, 4'h6);
    step();
    push_a(1'b1, 4'h6);
    exp_d.push_back('{sel: 1'b1, src: 4'h6, data: 32'h36});
    s_d_valid = 1'b1; s_d_source = 5'h16; s_d_data = 32'h36; m1_d_ready = 1'b1;
    step();
    drive_m1(1'b0, 4'h0); s_a_ready = 1'b0; s_d_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding1_o !== 2'd1) begin
      errors++;
      $display("FAIL same_cycle got cnt1=%0d want 1", outstanding1_o);
    end
    d_beat(1'b1, 4'h6, 32'h37);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || outstanding0_o !== 2'd0) begin
      errors++;
      $display("FAIL err_pre got err=%b cnt0=%0d want 0 0", err_o, outstanding0_o);
    end
    d_beat(1'b0, 4'h9, 32'h49);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || outstanding0_o !== 2'd0) begin
      errors++;
      $display("FAIL err_underflow got err=%b cnt0=%0d want 1 0", err_o, outstanding0_o);
    end
  endtask

  task automatic test_reset_mid_lock();
    drive_m0(1'b1, 4'h4); s_a_ready = 1'b1; push_a(1'b0, 4'h4);
    step();
    drive_m0(1'b1, 4'h8); s_a_ready = 1'b0;
    step();
    drive_m1(1'b1, 4'h3);
    rst = 1'b1;
    s_d_valid = 1'b1; s_d_source = 5'h04; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready} !== 6'b0) begin
      errors++;
      $display("FAIL rst_lock_handshakes got %b want 000000",
               {s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready});
    end
    step();
    @(negedge clk);
    checks++;
    if (outstanding0_o !== '0 || outstanding1_o !== '0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_lock_state got cnt0=%0d cnt1=%0d err=%b want 0 0 0",
               outstanding0_o, outstanding1_o, err_o);
    end
    rst = 1'b0; drive_m0(1'b0, 4'h0); s_d_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_a_valid !== 1'b1 || s_a_source !== 5'h13) begin
      errors++;
      $display("FAIL rst_unlock got v=%b src=%h want 1 13", s_a_valid, s_a_source);
    end
    step();
    drive_m1(1'b0, 4'h0);
  endtask

  initial begin
    rst = 1'b1;
    m0_a_param = 3'd0; m0_a_size = 4'd2; m0_a_mask = 4'hF; m0_a_corrupt = 1'b0;
    m1_a_param = 3'd0; m1_a_size = 4'd2; m1_a_mask = 4'hF; m1_a_corrupt = 1'b0;
    drive_m0(1'b0, 4'h0); drive_m1(1'b0, 4'h0);
    s_a_ready = 1'b0; s_d_valid = 1'b0; s_d_source = '0; s_d_data = '0;
    s_d_opcode = 3'd1; s_d_param = 2'd0; s_d_size = 4'd2; s_d_denied = 1'b0; s_d_corrupt = 1'b0;
    m0_d_ready = 1'b0; m1_d_ready = 1'b0;

    test_reset();
    test_round_robin();
    test_lock();
    test_limit();
    test_d_backpressure();
    test_simultaneous_and_err();
    test_reset_mid_lock();

    checks++;
    if (exp_a.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got a=%0d d=%0d want 0 0", exp_a.size(), exp_d.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
